// File: rtl/sprite_tex_loader.sv
// Sprite texture loader: packs an SD-card byte stream into RGB565 words and
// writes the bird image, then the pipe image, into their texture RAMs.
module sprite_tex_loader #(
  parameter int unsigned BIRD_WORDS     = 5250,
  parameter int unsigned PIPE_WORDS     = 40000,
  parameter bit          LOW_BYTE_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic        bird_load_en,
  output logic [12:0] bird_load_addr,
  output logic        pipe_load_en,
  output logic [15:0] pipe_load_addr,
  output logic [15:0] load_data,
  output logic        busy,
  output logic        load_done
);

  typedef enum logic [1:0] {IDLE, LOAD_BIRD, LOAD_PIPE, DONE} state_e;

  localparam logic [15:0] BIRD_LAST = 16'(BIRD_WORDS - 1);
  localparam logic [15:0] PIPE_LAST = 16'(PIPE_WORDS - 1);

  state_e      state_q;
  logic        phase_q;
  logic [15:0] cnt_q;
  logic [7:0]  hold_q;
  logic        src_ready_q;
  logic        bird_en_q;
  logic [12:0] bird_addr_q;
  logic        pipe_en_q;
  logic [15:0] pipe_addr_q;
  logic [15:0] data_q;
  logic        busy_q;
  logic        done_q;

  logic        xfer;
  logic        word_done;
  logic [15:0] word_d;

  // src_ready_q is high exactly in the two load states, so it doubles as the
  // "loading" qualifier for a byte transfer.
  assign xfer      = src_valid && src_ready_q;
  assign word_done = xfer && phase_q;
  assign word_d    = LOW_BYTE_FIRST ? {src_data, hold_q} : {hold_q, src_data};

  always_ff @(posedge clk) begin
    // NOTE: every register here, including the byte holding register, is
    // cleared by reset so an aborted load cannot leave a stale half-word.
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      hold_q      <= '0;
      src_ready_q <= 1'b0;
      bird_en_q   <= 1'b0;
      bird_addr_q <= '0;
      pipe_en_q   <= 1'b0;
      pipe_addr_q <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      bird_en_q <= 1'b0;
      pipe_en_q <= 1'b0;

      if (xfer) begin
        phase_q <= ~phase_q;
        if (!phase_q) hold_q <= src_data;
      end
      if (word_done) data_q <= word_d;

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= LOAD_BIRD;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            done_q      <= 1'b0;
            src_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        LOAD_BIRD: begin
          if (word_done) begin
            bird_en_q   <= 1'b1;
            bird_addr_q <= cnt_q[12:0];
            if (cnt_q == BIRD_LAST) begin
              state_q <= LOAD_PIPE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end
        LOAD_PIPE: begin
          if (word_done) begin
            pipe_en_q   <= 1'b1;
            pipe_addr_q <= cnt_q;
            cnt_q       <= cnt_q + 16'd1;
            if (cnt_q == PIPE_LAST) begin
              state_q     <= DONE;
              src_ready_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign src_ready      = src_ready_q;
  assign bird_load_en   = bird_en_q;
  assign bird_load_addr = bird_addr_q;
  assign pipe_load_en   = pipe_en_q;
  assign pipe_load_addr = pipe_addr_q;
  assign load_data      = data_q;
  assign busy           = busy_q;
  assign load_done      = done_q;

endmodule

// File: tb/tb_sprite_tex_loader.sv
// Self-checking bench for sprite_tex_loader: directed vector table, random
// valid gaps against a byte-count reference model, and reset/restart cases.
module tb_sprite_tex_loader;

  localparam int BW = 20;
  localparam int PW = 40;

  logic        clk = 1'b0;
  logic        rst, start, src_valid;
  logic [7:0]  src_data;

  logic        src_ready_0, bird_en_0, pipe_en_0, busy_0, done_0;
  logic [12:0] bird_addr_0;
  logic [15:0] pipe_addr_0, data_0;
  logic        src_ready_1, bird_en_1, pipe_en_1, busy_1, done_1;
  logic [12:0] bird_addr_1;
  logic [15:0] pipe_addr_1, data_1;

  always #5 clk = ~clk;

  sprite_tex_loader #(.BIRD_WORDS(BW), .PIPE_WORDS(PW), .LOW_BYTE_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready_0), .bird_load_en(bird_en_0), .bird_load_addr(bird_addr_0),
    .pipe_load_en(pipe_en_0), .pipe_load_addr(pipe_addr_0), .load_data(data_0),
    .busy(busy_0), .load_done(done_0));

  sprite_tex_loader #(.BIRD_WORDS(BW), .PIPE_WORDS(PW), .LOW_BYTE_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready_1), .bird_load_en(bird_en_1), .bird_load_addr(bird_addr_1),
    .pipe_load_en(pipe_en_1), .pipe_load_addr(pipe_addr_1), .load_data(data_1),
    .busy(busy_1), .load_done(done_1));

  int n_checks = 0;
  int n_errors = 0;
  int n_bird   = 0;
  int n_pipe   = 0;

  // Reference model: tracks only the number of bytes accepted in the current
  // load; word index, target RAM and address follow arithmetically from it.
  bit          m_loading = 1'b0;
  bit          m_done    = 1'b0;
  bit          m_ben     = 1'b0;
  bit          m_pen     = 1'b0;
  int          m_nb      = 0;
  logic [7:0]  m_first   = '0;
  logic [12:0] m_baddr   = '0;
  logic [15:0] m_paddr   = '0;
  logic [15:0] m_data    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit st, input bit v, input logic [7:0] d);
    bit was_loading;
    int w;
    if (r) begin
      m_loading = 1'b0; m_done = 1'b0; m_ben = 1'b0; m_pen = 1'b0;
      m_nb = 0; m_first = '0; m_baddr = '0; m_paddr = '0; m_data = '0;
    end else begin
      was_loading = m_loading;
      m_ben = 1'b0;
      m_pen = 1'b0;
      if (v && was_loading) begin
        if (m_nb % 2 == 1) begin
          w = m_nb / 2;
          m_data = {d, m_first};
          if (w < BW) begin m_ben = 1'b1; m_baddr = 13'(w); end
          else begin m_pen = 1'b1; m_paddr = 16'(w - BW); end
          if (w == BW + PW - 1) begin m_loading = 1'b0; m_done = 1'b1; end
        end else begin
          m_first = d;
        end
        m_nb++;
      end
      if (st && !was_loading) begin
        m_loading = 1'b1; m_done = 1'b0; m_nb = 0;
      end
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next
  // falling edge.
  task automatic cycle(input bit r, input bit st, input bit v, input logic [7:0] d);
    rst = r; start = st; src_valid = v; src_data = d;
    model_edge(r, st, v, d);
    @(negedge clk);
    check("src_ready", src_ready_0, m_loading);
    check("busy", busy_0, m_loading);
    check("load_done", done_0, m_done);
    check("bird_en", bird_en_0, m_ben);
    check("pipe_en", pipe_en_0, m_pen);
    check("bird_addr", bird_addr_0, m_baddr);
    check("pipe_addr", pipe_addr_0, m_paddr);
    check("strobe_excl", bird_en_0 && pipe_en_0, 1'b0);
    check("hbf_bird_en", bird_en_1, m_ben);
    check("hbf_pipe_en", pipe_en_1, m_pen);
    if (m_ben || m_pen) begin
      check("load_data", data_0, m_data);
      check("hbf_load_data", data_1, {m_data[7:0], m_data[15:8]});
    end
    if (bird_en_0) n_bird++;
    if (pipe_en_0) n_pipe++;
  endtask

  typedef struct {
    bit          r, st, v;
    logic [7:0]  d;
    bit          e_rdy, e_ben;
    logic [12:0] e_baddr;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int cyc, cb, cp;
    rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;

    tbl[0] = '{1, 0, 0, 8'h00, 0, 0, 13'd0, 16'h0000};
    tbl[1] = '{0, 1, 0, 8'h00, 1, 0, 13'd0, 16'h0000};
    tbl[2] = '{0, 0, 1, 8'h1F, 1, 0, 13'd0, 16'h0000};
    tbl[3] = '{0, 0, 0, 8'h00, 1, 0, 13'd0, 16'h0000};
    tbl[4] = '{0, 0, 1, 8'hF8, 1, 1, 13'd0, 16'hF81F};
    tbl[5] = '{0, 0, 1, 8'h34, 1, 0, 13'd0, 16'h0000};
    tbl[6] = '{0, 0, 1, 8'h12, 1, 1, 13'd1, 16'h1234};
    tbl[7] = '{0, 1, 0, 8'h00, 1, 0, 13'd1, 16'h0000};
    tbl[8] = '{0, 0, 1, 8'hCD, 1, 0, 13'd1, 16'h0000};
    tbl[9] = '{0, 0, 1, 8'hAB, 1, 1, 13'd2, 16'hABCD};

    @(negedge clk);

    // Directed vectors: reset, first words, a gap, start ignored while busy.
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].r, tbl[i].st, tbl[i].v, tbl[i].d);
      check($sformatf("tbl%0d_ready", i), src_ready_0, tbl[i].e_rdy);
      check($sformatf("tbl%0d_bird_en", i), bird_en_0, tbl[i].e_ben);
      check($sformatf("tbl%0d_bird_addr", i), bird_addr_0, tbl[i].e_baddr);
      if (tbl[i].e_ben) check($sformatf("tbl%0d_data", i), data_0, tbl[i].e_data);
      if (i == 0) begin
        check("reset_load_data", data_0, 16'h0);
        check("reset_pipe_addr", pipe_addr_0, 16'h0);
        check("reset_pipe_en", pipe_en_0, 1'b0);
        check("reset_busy", busy_0, 1'b0);
        check("reset_done", done_0, 1'b0);
      end
      if (i == 4) check("hbf_first_word", data_1, 16'h1FF8);
    end

    // Random valid gaps (about 50%) with stray start pulses while busy.
    cyc = 0;
    while (m_loading && cyc < 5000) begin
      cycle(1'b0, ($urandom % 16) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
      cyc++;
    end
    check("random_run_timeout", cyc < 5000, 1'b1);
    check("random_bird_strobes", n_bird, BW);
    check("random_pipe_strobes", n_pipe, PW);
    check("random_done", done_0, 1'b1);

    // Bytes offered in DONE are refused.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
    check("done_not_ready", src_ready_0, 1'b0);

    // Restart from DONE: load_done drops and src_ready rises next cycle.
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check("restart_done_low", done_0, 1'b0);
    check("restart_ready", src_ready_0, 1'b1);

    // Continuous stream: check bird->pipe boundary spacing and totals.
    n_bird = 0; n_pipe = 0; cyc = 0; cb = -100; cp = -200;
    while (m_loading && cyc < 2 * (BW + PW) + 10) begin
      cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
      if (bird_en_0 && bird_addr_0 == 13'(BW - 1)) cb = cyc;
      if (pipe_en_0 && pipe_addr_0 == 16'd0) cp = cyc;
      cyc++;
    end
    check("cont_timeout", cyc < 2 * (BW + PW) + 10, 1'b1);
    check("cont_boundary_gap", cp - cb, 2);
    check("cont_bird_strobes", n_bird, BW);
    check("cont_pipe_strobes", n_pipe, PW);
    check("cont_done", done_0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("cont_ready_after", src_ready_0, 1'b0);

    // Abort mid-pipe with half a word pending, then reload from address 0.
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cyc = 0;
    while (m_nb < 2 * (BW + PW / 2) + 1 && cyc < 500) begin
      cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
      cyc++;
    end
    check("abort_reach_timeout", cyc < 500, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 8'h55);
    check("abort_ready", src_ready_0, 1'b0);
    check("abort_bird_en", bird_en_0, 1'b0);
    check("abort_pipe_en", pipe_en_0, 1'b0);
    check("abort_bird_addr", bird_addr_0, 13'd0);
    check("abort_pipe_addr", pipe_addr_0, 16'd0);
    check("abort_data", data_0, 16'd0);
    check("abort_busy", busy_0, 1'b0);
    check("abort_done", done_0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'h66);
    check("abort_no_stray", bird_en_0 || pipe_en_0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h11);
    cycle(1'b0, 1'b0, 1'b1, 8'h22);
    check("reload_bird_en", bird_en_0, 1'b1);
    check("reload_bird_addr", bird_addr_0, 13'd0);
    check("reload_data", data_0, 16'h2211);

    n_bird = 1; n_pipe = 0; cyc = 0;
    while (m_loading && cyc < 5000) begin
      cycle(1'b0, 1'b0, $urandom_range(0, 1) == 1, 8'($urandom));
      cyc++;
    end
    check("reload_timeout", cyc < 5000, 1'b1);
    check("reload_bird_strobes", n_bird, BW);
    check("reload_pipe_strobes", n_pipe, PW);
    check("reload_done", done_0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
